fetch_queue: RTL

- Parametrised successor to the single-shot fetch unit: prefetches instruction bytes from word-wide memory into a circular byte queue.
- Presents decode with a window of up to WIN_BYTES bytes plus the window PC. Decode reports how many bytes it consumed.
- Supports an initial PC load from address 0 and PC redirects, including redirects while a memory request is in flight.
- Sits between the memory module and decode.

---
 rtl/fetch_queue.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Prefetching byte queue between word-wide memory and decode; presents a window of bytes at o_win_pc.
// Optional: define FETCH_QUEUE_CONSUME_CHECK_EN to flag and report out-of-range consumes on o_error.

module fetch_queue_lane #(
    parameter int QUEUE_BYTES = 16,
    parameter int PTR_W       = $clog2(QUEUE_BYTES),
    parameter int LANE        = 0
) (
    input  logic [QUEUE_BYTES-1:0][7:0] q,
    input  logic [PTR_W-1:0]            head,
    input  logic [PTR_W:0]              count,
    output logic [7:0]                  lane_byte
);
    logic [PTR_W-1:0] idx;

    assign idx       = head + PTR_W'(LANE);
    assign lane_byte = (count > (PTR_W+1)'(LANE)) ? q[idx] : 8'h00;
endmodule

module fetch_queue #(
    parameter int ADDR_W      = 32,
    parameter int WORD_BYTES  = 4,
    parameter int QUEUE_BYTES = 16,
    parameter int WIN_BYTES   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_mem_valid,
    input  logic [8*WORD_BYTES-1:0] i_mem_data,
    output logic                    o_addr_valid,
    output logic [ADDR_W-1:0]       o_addr,
    input  logic                    i_redirect,
    input  logic [ADDR_W-1:0]       i_redirect_pc,
    input  logic                    i_consume_valid,
    input  logic [3:0]              i_consume_len,
    output logic [8*WIN_BYTES-1:0]  o_win,
    output logic [3:0]              o_win_count,
    output logic [ADDR_W-1:0]       o_win_pc,
    output logic                    o_win_valid,
    output logic                    o_ready,
    output logic                    o_error
);
    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int PTR_W = $clog2(QUEUE_BYTES);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_RESET, ST_INIT_PC, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } mem_req_t;

    state_t                     state;
    mem_req_t                   req;
    logic [QUEUE_BYTES-1:0][7:0] q;
    logic [PTR_W-1:0]           head;
    logic [CNT_W-1:0]           count;
    logic [ADDR_W-1:0]          fetch_pc;
    logic [ADDR_W-1:0]          win_pc;

    logic [OFF_W-1:0]           fetch_off;
    logic [ADDR_W-1:0]          fetch_base;
    logic [PTR_W-1:0]           tail;
    logic [CNT_W-1:0]           free_bytes;
    logic [CNT_W-1:0]           append_len;
    logic [CNT_W-1:0]           req_len;
    logic [CNT_W-1:0]           consume_len;
    logic [3:0]                 win_count;
    logic                       resp;
    logic                       run_resp;
    logic                       consume;
    logic                       can_issue;
    logic [WIN_BYTES-1:0][7:0]  win_bytes;

    assign fetch_off  = fetch_pc[OFF_W-1:0];
    assign fetch_base = {fetch_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign tail       = head + count[PTR_W-1:0];
    assign free_bytes = CNT_W'(QUEUE_BYTES) - count;
    assign append_len = CNT_W'(WORD_BYTES) - CNT_W'(fetch_off);
    assign win_count  = (count > CNT_W'(WIN_BYTES)) ? 4'(WIN_BYTES) : count[3:0];

    assign resp      = req.valid && i_mem_valid;
    assign run_resp  = (state == ST_RUN) && resp && !i_redirect;
    assign consume   = (state == ST_RUN) && i_consume_valid && !i_redirect;
    assign can_issue = (state == ST_RUN) && !req.valid && !i_redirect &&
                       (free_bytes >= CNT_W'(WORD_BYTES));

    // Over-long consumes are clamped so head never passes the tail.
    assign req_len     = CNT_W'(i_consume_len);
    assign consume_len = consume ? ((req_len > count) ? count : req_len) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_RESET;
            req      <= '0;
            head     <= '0;
            count    <= '0;
            fetch_pc <= '0;
            win_pc   <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    state     <= ST_INIT_PC;
                    req.valid <= 1'b1;
                    req.addr  <= '0;
                end
                ST_INIT_PC: begin
                    if (resp) begin
                        state     <= ST_RUN;
                        req.valid <= 1'b0;
                        fetch_pc  <= i_mem_data[ADDR_W-1:0];
                        win_pc    <= i_mem_data[ADDR_W-1:0];
                    end
                end
                default: begin
                    if (resp) begin
                        req.valid <= 1'b0;
                        req.addr  <= '0;
                    end else if (can_issue) begin
                        req.valid <= 1'b1;
                        req.addr  <= fetch_base;
                    end

                    if (i_redirect) begin
                        count    <= '0;
                        fetch_pc <= i_redirect_pc;
                        win_pc   <= i_redirect_pc;
                        state    <= (req.valid && !i_mem_valid) ? ST_DRAIN : ST_RUN;
                    end else if (state == ST_DRAIN) begin
                        if (resp)
                            state <= ST_RUN;
                    end else begin
                        if (run_resp)
                            fetch_pc <= fetch_base + ADDR_W'(WORD_BYTES);
                        head   <= head + consume_len[PTR_W-1:0];
                        win_pc <= win_pc + ADDR_W'(consume_len);
                        count  <= count - consume_len + (run_resp ? append_len : '0);
                    end
                end
            endcase
        end
    end

    // Appended bytes land past the current tail, so they never collide with a same-cycle consume.
    always_ff @(posedge clk) begin
        if (run_resp) begin
            for (int j = 0; j < WORD_BYTES; j++) begin
                if (OFF_W'(j) >= fetch_off)
                    q[tail + PTR_W'(j) - PTR_W'(fetch_off)] <= i_mem_data[8*j +: 8];
            end
        end
    end

    for (genvar l = 0; l < WIN_BYTES; l++) begin : g_lane
        fetch_queue_lane #(
            .QUEUE_BYTES(QUEUE_BYTES),
            .PTR_W      (PTR_W),
            .LANE       (l)
        ) u_lane (
            .q        (q),
            .head     (head),
            .count    (count),
            .lane_byte(win_bytes[l])
        );
    end

`ifdef FETCH_QUEUE_CONSUME_CHECK_EN
    logic error;
    logic bad_consume;

    assign bad_consume = consume && ((i_consume_len == 4'd0) || (i_consume_len > win_count));

    always_ff @(posedge clk) begin
        if (!reset) begin
            error <= 1'b0;
        end else if (bad_consume) begin
            error <= 1'b1;
            $display("fetch_queue: bad consume pc=%h len=%0d count=%0d", win_pc, i_consume_len, count);
        end
    end

    assign o_error = error;
`else
    assign o_error = 1'b0;
`endif

    assign o_addr_valid = req.valid;
    assign o_addr       = req.valid ? req.addr : '0;
    assign o_win        = win_bytes;
    assign o_win_count  = win_count;
    assign o_win_pc     = win_pc;
    assign o_ready      = (state == ST_RUN);
    assign o_win_valid  = (state == ST_RUN) && (win_count != 4'd0);
endmodule
